// File: rtl/datapath.sv
// datapath: single-cycle ARM-subset datapath (PC, 15-entry register file, extender, shifter, ALU, writeback)
// Ports: clk/reset (async, active-low); decoded controls RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
//        MemWrite, MemtoReg, PCSrc, BL, ShiftEn; memory side PC, Instr, ALUResult, WriteData, ReadData;
//        controller side Op, ALUFlags {N,Z,C,V}.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we3,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [3:0]  wa3,
  input  logic [31:0] wd3,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs_q [0:14];
  logic [31:0] regs_d [0:14];
  always_comb begin
    regs_d = regs_q;
    if (we3 && wa3 != 4'd15) regs_d[wa3] = wd3;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
  // R15 is not stored; it reads as PC+8
  assign rd1 = ra1 == 4'd15 ? r15 : regs_q[ra1];
  assign rd2 = ra2 == 4'd15 ? r15 : regs_q[ra2];
endmodule

module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  RegSrc,
  input  logic        RegWrite,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUSrc,
  input  logic [2:0]  ALUControl,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        PCSrc,
  input  logic        BL,
  input  logic        ShiftEn,
  output logic [31:0] PC,
  output logic [1:0]  Op,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  input  logic [31:0] Instr,
  output logic [3:0]  ALUFlags
);
  logic [31:0] pc_q, pc_d, PCPlus4, PCPlus8;
  logic [3:0]  RA1, RA2, WA3;
  logic [31:0] WD3, rd1, rd2, ExtImm, imm8, asr, shifted, SrcA, SrcB, bx, Result;
  logic [4:0]  rot, sh;
  logic [32:0] sum;
  logic        sub, arith;
  logic        unused;
  assign unused = ^{MemWrite, Instr[31:28], Instr[25:24]};
  assign PCPlus4 = pc_q + 32'd4;
  assign PCPlus8 = pc_q + 32'd8;
  assign RA1 = RegSrc[0] ? 4'd15 : Instr[19:16];
  assign RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  assign WA3 = BL ? 4'd14 : Instr[15:12];
  assign WD3 = BL ? PCPlus4 : Result;
  regfile rf (
    .clk(clk), .reset(reset), .we3(RegWrite), .ra1(RA1), .ra2(RA2), .wa3(WA3),
    .wd3(WD3), .r15(PCPlus8), .rd1(rd1), .rd2(rd2)
  );
  assign rot  = {Instr[11:8], 1'b0};
  assign sh   = Instr[11:7];
  assign imm8 = {24'd0, Instr[7:0]};
  assign asr  = $signed(rd2) >>> sh;
  always_comb begin
    ExtImm = ImmSrc == 2'b00 ? (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot})) :
             ImmSrc == 2'b01 ? {20'd0, Instr[11:0]} :
             ImmSrc == 2'b10 ? {{6{Instr[23]}}, Instr[23:0], 2'b00} : 32'd0;
    shifted = !ShiftEn           ? rd2 :
              Instr[6:5] == 2'b00 ? rd2 << sh :
              Instr[6:5] == 2'b01 ? rd2 >> sh :
              Instr[6:5] == 2'b10 ? asr : (rd2 >> sh) | (rd2 << (6'd32 - {1'b0, sh}));
    SrcA = rd1;
    SrcB = ALUSrc == 2'b00 ? shifted : ALUSrc == 2'b10 ? 32'd0 : ExtImm;
    sub   = ALUControl == 3'b001;
    arith = ALUControl == 3'b000 || sub || ALUControl == 3'b111;
    // subtract as A + ~B + 1 so the carry-out means "no borrow"
    bx  = sub ? ~SrcB : SrcB;
    sum = {1'b0, SrcA} + {1'b0, bx} + {32'd0, sub};
    ALUResult = arith                 ? sum[31:0] :
                ALUControl == 3'b010 ? SrcA & SrcB :
                ALUControl == 3'b011 ? SrcA | SrcB :
                ALUControl == 3'b100 ? SrcA ^ SrcB :
                ALUControl == 3'b101 ? SrcA & ~SrcB : SrcB;
    ALUFlags = {ALUResult[31], ALUResult == 32'd0, arith & sum[32],
                arith & (SrcA[31] == bx[31]) & (sum[31] != SrcA[31])};
    Result = MemtoReg ? ReadData : ALUResult;
    pc_d   = PCSrc ? Result : PCPlus4;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else pc_q <= pc_d;
  end
  assign PC        = pc_q;
  assign WriteData = rd2;
  assign Op        = Instr[27:26];
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: scoreboard bench for the single-cycle datapath
module tb_datapath;
  logic        clk = 0, reset;
  logic [1:0]  RegSrc, ImmSrc, ALUSrc, Op;
  logic        RegWrite, MemWrite, MemtoReg, PCSrc, BL, ShiftEn;
  logic [2:0]  ALUControl;
  logic [31:0] PC, ALUResult, WriteData, ReadData, Instr;
  logic [3:0]  ALUFlags;
  logic [31:0] pc_m;
  int n_cmp = 0, n_err = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  datapath dut (
    .clk(clk), .reset(reset), .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .PCSrc(PCSrc), .BL(BL), .ShiftEn(ShiftEn), .PC(PC), .Op(Op), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .Instr(Instr), .ALUFlags(ALUFlags)
  );
  always #5 clk = ~clk;
  // PC reference: sequential fetch, and the only taken branch in this bench lands at 0x20
  always @(posedge clk or negedge reset) pc_m <= !reset ? 32'd0 : PCSrc ? 32'h20 : pc_m + 32'd4;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int s);
    case (s)
      0: return PC;
      1: return ALUResult;
      2: return {28'd0, ALUFlags};
      3: return WriteData;
      4: return dut.ExtImm;
      5: return dut.SrcA;
      6: return dut.SrcB;
      default: return {30'd0, Op};
    endcase
  endfunction
  localparam int S_PC = 0, S_RES = 1, S_FLG = 2, S_WD = 3, S_EXT = 4, S_A = 5, S_B = 6, S_OP = 7;
  task automatic want(input string tag, input int s, input logic [31:0] e);
    sb.push_back('{tag, s, e});
  endtask
  // compare at the falling edge, then let the rising edge commit state
  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    RegSrc = 0; RegWrite = 0; ImmSrc = 0; ALUSrc = 0; ALUControl = 0; MemWrite = 0;
    MemtoReg = 0; PCSrc = 0; BL = 0; ShiftEn = 0; ReadData = 0; Instr = 0;
  endtask
  task automatic load(input logic [3:0] r, input logic [31:0] v);
    idle();
    Instr = {16'd0, r, 12'd0}; MemtoReg = 1; ReadData = v; RegWrite = 1;
    drain();
    idle();
  endtask
  typedef struct {logic [2:0] ac; logic [31:0] res; logic [3:0] flg;} logic_t;
  logic_t lt[5] = '{'{3'b010, 32'h22222222, 4'b0000}, '{3'b011, 32'h33333333, 4'b0000},
                    '{3'b100, 32'h11111111, 4'b0000}, '{3'b101, 32'h00000000, 4'b0100},
                    '{3'b110, 32'h33333333, 4'b0000}};
  typedef struct {logic [31:0] ins; logic [31:0] res;} sh_t;
  sh_t st[4] = '{'{32'h00000246, 32'hF8000000}, '{32'h00000226, 32'h08000000},
                 '{32'h000000E7, 32'h80000002}, '{32'h00000006, 32'h80000000}};
  initial begin
    reset = 0;
    idle();
    want("reset_pc", S_PC, 32'h0);
    drain();
    reset = 1;
    drain(); drain(); drain();
    want("pc_after_3", S_PC, 32'hC);
    drain();
    load(2, 32'h22222222); load(3, 32'h33333333); load(4, 32'h00001000);
    load(5, 32'h80000000); load(6, 32'h80000000); load(7, 32'h5); load(8, 32'h5);
    Instr = 32'hE0821003;
    want("add_srca", S_A, 32'h22222222); want("add_srcb", S_B, 32'h33333333);
    want("add_res", S_RES, 32'h55555555); want("add_flg", S_FLG, 32'h0);
    want("add_wd", S_WD, 32'h33333333);
    drain();
    foreach (lt[i]) begin
      ALUControl = lt[i].ac;
      want($sformatf("logic%0d_res", i), S_RES, lt[i].res);
      want($sformatf("logic%0d_flg", i), S_FLG, {28'd0, lt[i].flg});
      drain();
    end
    idle();
    Instr = 32'hE2821064; ALUSrc = 2'b11;
    want("addi_ext", S_EXT, 32'h64); want("addi_res", S_RES, 32'h22222286);
    drain();
    ALUSrc = 2'b00;
    want("addi_reg_srcb", S_B, 32'h1000); want("addi_reg_res", S_RES, 32'h22223222);
    drain();
    ALUSrc = 2'b10;
    want("srcb_zero", S_B, 32'h0); want("srcb_zero_res", S_RES, 32'h22222222);
    drain();
    idle();
    Instr = 32'hE5921004; ImmSrc = 2'b01; ALUSrc = 2'b01; ALUControl = 3'b111;
    MemtoReg = 1; RegWrite = 1; ReadData = 32'h12345678;
    want("ldr_ext", S_EXT, 32'h4); want("ldr_res", S_RES, 32'h22222226); want("ldr_op", S_OP, 32'h1);
    drain();
    idle();
    Instr = 32'h1;
    want("ldr_r1", S_WD, 32'h12345678);
    drain();
    Instr = 32'h00050006;
    want("ovf_res", S_RES, 32'h0); want("ovf_flg", S_FLG, 32'h7);
    drain();
    Instr = 32'h00070008; ALUControl = 3'b001;
    want("sub_eq_res", S_RES, 32'h0); want("sub_eq_flg", S_FLG, 32'h6);
    drain();
    Instr = 32'h00070006;
    want("sub_ovf_res", S_RES, 32'h80000005); want("sub_ovf_flg", S_FLG, 32'h9);
    drain();
    idle();
    ALUControl = 3'b110; ShiftEn = 1;
    foreach (st[i]) begin
      Instr = st[i].ins;
      want($sformatf("shift%0d", i), S_RES, st[i].res);
      drain();
    end
    Instr = 32'h00000246;
    want("shift_wd_raw", S_WD, 32'h80000000);
    drain();
    ShiftEn = 0;
    want("noshift", S_RES, 32'h80000000);
    drain();
    idle();
    Instr = 32'h000004FF;
    want("ext_rot", S_EXT, 32'hFF000000);
    drain();
    ImmSrc = 2'b11;
    want("ext_zero", S_EXT, 32'h0);
    drain();
    ImmSrc = 2'b10; Instr = 32'h00FFFFFE;
    want("ext_branch_neg", S_EXT, 32'hFFFFFFF8);
    drain();
    idle();
    Instr = 32'h00009009; MemtoReg = 1; ReadData = 32'hA5A5A5A5; RegWrite = 1;
    want("rw_old", S_WD, 32'h0);
    drain();
    idle();
    Instr = 32'h9;
    want("rw_new", S_WD, 32'hA5A5A5A5);
    drain();
    idle();
    RegSrc = 2'b01;
    want("r15_read", S_A, pc_m + 32'd8);
    drain();
    idle();
    Instr = 32'h0000F00F; MemtoReg = 1; ReadData = 32'hDEAD; RegWrite = 1;
    want("r15_before", S_WD, pc_m + 32'd8);
    drain();
    idle();
    Instr = 32'hF;
    want("r15_ignored", S_WD, pc_m + 32'd8);
    drain();
    idle();
    reset = 0;
    #1;
    Instr = 32'h2;
    want("midreset_pc", S_PC, 32'h0); want("midreset_r2", S_WD, 32'h0);
    drain();
    reset = 1;
    drain(); drain(); drain(); drain();
    Instr = 32'h00000002; ImmSrc = 2'b10; ALUSrc = 2'b01; RegSrc = 2'b01;
    ALUControl = 3'b000; PCSrc = 1; BL = 1; RegWrite = 1;
    want("bl_pc", S_PC, 32'h10); want("bl_ext", S_EXT, 32'h8);
    want("bl_srca", S_A, 32'h18); want("bl_res", S_RES, 32'h20);
    drain();
    idle();
    Instr = 32'hE;
    want("bl_pc_next", S_PC, 32'h20); want("bl_lr", S_WD, 32'h14);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle ARM-subset processor datapath: PC register, 15-entry register file, immediate extender, barrel shifter, ALU with NZCV flags, and result/writeback muxing.
- Driven by an external controller through decoded control inputs. Talks to external instruction/data memories through PC, Instr, ALUResult, WriteData and ReadData.
- Purely structural/combinational apart from the PC and the register file.

Parameters:
- None (data width fixed at 32, register index width fixed at 4).

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- RegSrc  in  2  register read-address select
- RegWrite  in  1  register-file write enable
- ImmSrc  in  2  immediate-format select
- ALUSrc  in  2  ALU operand-B select
- ALUControl  in  3  ALU operation
- MemWrite  in  1  memory write strobe; accepted but unused inside the block
- MemtoReg  in  1  Result = ReadData when 1, else ALUResult
- PCSrc  in  1  PCNext = Result when 1, else PC+4
- BL  in  1  branch-with-link: write PC+4 to R14
- ShiftEn  in  1  apply the immediate-amount shifter to the register operand B
- PC  out  32  current program counter
- Op  out  2  Instr[27:26], forwarded to the controller
- ALUResult  out  32  ALU output / memory address
- WriteData  out  32  unshifted register read port 2 (store data)
- ReadData  in  32  data memory read value
- Instr  in  32  current instruction
- ALUFlags  out  4  {N,Z,C,V} from the current ALU operation

Behaviour:
- Reset (reset==0, asynchronous): PC=0; R0–R14=0. All other outputs are combinational from state and inputs.
- PC register:
  - updates on rising clk to PCNext = PCSrc ? Result : PC+4.
  - PCPlus8 = PC+8.
- Register file:
  - instance name rf, with combinational read outputs rd1 and rd2. These hierarchical names are fixed; verification forces them.
  - RA1 = RegSrc[0] ? 4'd15 : Instr[19:16].
  - RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
  - Reading R15 returns PCPlus8.
- Register write:
  - on rising clk when RegWrite=1.
  - address WA3 = BL ? 14 : Instr[15:12]; data WD3 = BL ? PC+4 : Result.
  - Writes to R15 are ignored; the PC changes only through PCSrc.
  - A write and a read of the same register in one cycle returns the old value; the new value is visible after the edge.
- Extender (ExtImm, internal signal name fixed):
  - ImmSrc 00: Instr[7:0] zero-extended, rotated right by 2*Instr[11:8].
  - ImmSrc 01: Instr[11:0] zero-extended.
  - ImmSrc 10: Instr[23:0] sign-extended, shifted left by 2.
  - ImmSrc 11: 0.
- Shifter on rd2:
  - when ShiftEn=1: type Instr[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), amount Instr[11:7]. Amount 0 passes rd2 unchanged.
  - when ShiftEn=0: passes rd2 unchanged.
- Operands (internal names SrcA/SrcB fixed):
  - SrcA = rd1.
  - SrcB by ALUSrc: 00 shifted register, 01 ExtImm, 10 32'd0, 11 ExtImm.
- ALU by ALUControl (32-bit, wrap-around):
  - 000 A+B
  - 001 A−B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 A&~B
  - 110 B
  - 111 A+B (address add)
- Flags:
  - N = ALUResult[31]; Z = (ALUResult==0).
  - Arithmetic ops: C = carry-out of the 33-bit add; for subtract, C = 1 when no borrow. V = signed overflow.
  - Logical/move ops: C=0, V=0.
- Result = MemtoReg ? ReadData : ALUResult.
- WriteData = rd2 (unshifted).
- Op = Instr[27:26].
- Reset asserted mid-cycle: PC and registers clear immediately. The pending write is discarded.

Test Plan:
- Reset: hold reset=0, then release, with PCSrc=0 → PC=0x00000000; after 3 rising edges PC=0x0000000C.
- Register ADD: Instr=E0821003, ALUSrc=00, ALUControl=000, ShiftEn=0, rd1 forced to 22222222, rd2 forced to 33333333 → SrcA=22222222, SrcB=33333333, ALUResult=55555555, ALUFlags=0000.
- Immediate ADD: Instr=E2821064, ImmSrc=00, ALUSrc=11, rd1=22222222 → ExtImm=00000064, ALUResult=22222286. With ALUSrc=00 and rd2 released, SrcB equals the R4 contents instead.
- LDR: Instr=E5921004, ImmSrc=01, ALUSrc=01, ALUControl=111, MemtoReg=1, RegWrite=1, ReadData=12345678, rd1=22222222 → ExtImm=00000004, ALUResult=22222226; after the clock edge R1=12345678.
- Flags: A=B=0x80000000 with ALUControl=000 → result 0, NZCV=0111. A=5, B=5 with ALUControl=001 → result 0, NZCV=0110.
- Branch/link: ImmSrc=10, Instr[23:0]=000002, ALUSrc=01, RA1=15, PCSrc=1, BL=1, RegWrite=1, PC=0x10 → after the edge PC=0x20 and R14=0x14.
